// File: rtl/dram_arbiter_pkg.sv
// dram_arbiter_pkg: owner encoding, FSM state type and width defaults shared by the arbiter files
package dram_arbiter_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;
  typedef enum logic [1:0] {OWNER_NONE = 2'b00, OWNER_IO = 2'b01, OWNER_CPU = 2'b10} owner_t;
  typedef enum logic [1:0] {IDLE = 2'b00, OWN_IO = 2'b01, OWN_CPU = 2'b10} state_t;
endpackage

// File: rtl/dram_arbiter_burst.sv
// arb_burst_counter: per-owner beat count that saturates at the burst limit and clears on ownership change
module arb_burst_counter #(
  parameter int MAX_BURST = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic beat,
  input  logic clear,
  output logic limit
);
  localparam int CW = $clog2(MAX_BURST) + 1;
  logic [CW-1:0] count;
  assign limit = count == CW'(MAX_BURST - 1);
  always_ff @(posedge clk)
    if (!reset) count <= '0;
    else if (clear) count <= '0;
    else if (beat && !limit) count <= count + 1'b1;
endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: two-port (IO/CPU) burst-fair arbiter in front of a single-port DRAM
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] io_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              hold_cpu,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_read,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [1:0]        owner,
  output logic              busy
);
  state_t state, next_state;
  owner_t last_owner;
  logic io_beat, cpu_beat, beat, cpu_elig, limit, sel_we, io_pend, cpu_pend;
  logic [ADDR_W-1:0] sel_addr, addr_q;
  logic [DATA_W-1:0] sel_din, din_q, io_rdata_q, cpu_rdata_q;
  assign io_beat  = io_req & io_gnt;
  assign cpu_beat = cpu_req & cpu_gnt;
  assign beat     = io_beat | cpu_beat;
  assign cpu_elig = cpu_req & ~hold_cpu;
  always_ff @(posedge clk)
    if (!reset) begin
      state      <= IDLE;
      last_owner <= OWNER_CPU;
    end else begin
      state <= next_state;
      if (next_state == OWN_IO) last_owner <= OWNER_IO;
      else if (next_state == OWN_CPU) last_owner <= OWNER_CPU;
    end
  // limit only matters on a beat; an owner holding req with its gnt is always beating
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = (io_req && cpu_elig) ? (last_owner == OWNER_IO ? OWN_CPU : OWN_IO) :
                            io_req ? OWN_IO : cpu_elig ? OWN_CPU : IDLE;
      OWN_IO:  next_state = !io_req ? IDLE : (limit && cpu_elig) ? OWN_CPU : OWN_IO;
      OWN_CPU: next_state = hold_cpu ? (io_req ? OWN_IO : IDLE) : !cpu_req ? IDLE :
                            (limit && io_req) ? OWN_IO : OWN_CPU;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    io_gnt  = state == OWN_IO;
    cpu_gnt = state == OWN_CPU;
    owner   = state;
    busy    = state != IDLE;
  end
  arb_burst_counter #(.MAX_BURST(MAX_BURST)) u_burst (
    .clk  (clk),
    .reset(reset),
    .beat (beat),
    .clear(state != next_state),
    .limit(limit)
  );
  assign sel_addr  = cpu_beat ? cpu_addr : io_addr;
  assign sel_din   = cpu_beat ? cpu_wdata : io_wdata;
  assign sel_we    = cpu_beat ? cpu_we : io_we;
  assign ram_addr  = beat ? sel_addr : addr_q;
  assign ram_din   = beat ? sel_din : din_q;
  assign ram_write = beat & sel_we;
  assign ram_read  = beat & ~sel_we;
  // pending flags capture the reading port at the beat, so returns route correctly across handovers
  always_ff @(posedge clk)
    if (!reset) begin
      addr_q      <= '0;
      din_q       <= '0;
      io_pend     <= 1'b0;
      cpu_pend    <= 1'b0;
      io_rdata_q  <= '0;
      cpu_rdata_q <= '0;
    end else begin
      if (beat) begin
        addr_q <= sel_addr;
        din_q  <= sel_din;
      end
      io_pend  <= io_beat & ~io_we;
      cpu_pend <= cpu_beat & ~cpu_we;
      if (io_pend) io_rdata_q <= ram_dout;
      if (cpu_pend) cpu_rdata_q <= ram_dout;
    end
  assign io_rvalid  = io_pend;
  assign cpu_rvalid = cpu_pend;
  assign io_rdata   = io_pend ? ram_dout : io_rdata_q;
  assign cpu_rdata  = cpu_pend ? ram_dout : cpu_rdata_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed checks of arbitration, bursts, hold_cpu, read routing and reset
module tb_dram_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  logic io_req = 0, io_we = 0, cpu_req = 0, cpu_we = 0, hold_cpu = 0;
  logic [15:0] io_addr = 0, cpu_addr = 0, ram_addr;
  logic [7:0] io_wdata = 0, cpu_wdata = 0, io_rdata, cpu_rdata, ram_din, ram_dout = 0;
  logic io_gnt, io_rvalid, cpu_gnt, cpu_rvalid, ram_read, ram_write, busy;
  logic [1:0] owner;
  logic [7:0] mem [0:255];
  int checks = 0, failures = 0;
  dram_arbiter dut (
    .clk(clk), .reset(reset),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .hold_cpu(hold_cpu), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_read(ram_read), .ram_write(ram_write), .ram_dout(ram_dout),
    .owner(owner), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr[7:0]] <= ram_din;
    if (ram_read) ram_dout <= mem[ram_addr[7:0]];
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  task automatic test_reset();
    reset = 0;
    step();
    step();
    mid();
    checks++;
    if ({owner, busy, io_gnt, cpu_gnt, io_rvalid, cpu_rvalid, ram_read, ram_write} !== 9'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {owner, busy, io_gnt, cpu_gnt, io_rvalid, cpu_rvalid, ram_read, ram_write});
    end
    checks++;
    if ({ram_addr, ram_din, io_rdata, cpu_rdata} !== 40'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {ram_addr, ram_din, io_rdata, cpu_rdata});
    end
    step();
    reset = 1;
  endtask
  task automatic test_io_write();
    io_req = 1; io_we = 1; io_addr = 16'h0010; io_wdata = 8'hA5;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
    mid();
    checks++;
    if ({io_gnt, cpu_gnt} !== 2'b00) begin
      failures++;
      $display("FAIL first_cycle_gnt got=%b exp=00", {io_gnt, cpu_gnt});
    end
    step();
    mid();
    checks++;
    if ({io_gnt, cpu_gnt, owner} !== 4'b1001) begin
      failures++;
      $display("FAIL tie_io_wins got=%b exp=1001", {io_gnt, cpu_gnt, owner});
    end
    checks++;
    if ({ram_write, ram_read, ram_addr, ram_din} !== {2'b10, 16'h0010, 8'hA5}) begin
      failures++;
      $display("FAIL io_write_beat got=%h exp=%h", {ram_write, ram_read, ram_addr, ram_din}, {2'b10, 16'h0010, 8'hA5});
    end
  endtask
  task automatic test_io_read();
    step();
    io_we = 0;
    mid();
    checks++;
    if ({ram_read, ram_write, ram_addr} !== {2'b10, 16'h0010}) begin
      failures++;
      $display("FAIL io_read_beat got=%h exp=%h", {ram_read, ram_write, ram_addr}, {2'b10, 16'h0010});
    end
    step();
    io_req = 0; cpu_req = 0;
    mid();
    checks++;
    if ({io_rvalid, cpu_rvalid, io_rdata} !== {2'b10, 8'hA5}) begin
      failures++;
      $display("FAIL io_read_return got=%h exp=%h", {io_rvalid, cpu_rvalid, io_rdata}, {2'b10, 8'hA5});
    end
    step();
    mid();
    checks++;
    if ({owner, io_rvalid, io_rdata} !== {3'b000, 8'hA5}) begin
      failures++;
      $display("FAIL idle_rdata_hold got=%h exp=%h", {owner, io_rvalid, io_rdata}, {3'b000, 8'hA5});
    end
  endtask
  task automatic test_alternation();
    logic exp_cpu;
    step();
    io_req = 1; io_we = 1; io_addr = 16'h0100; io_wdata = 8'h11;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0200; cpu_wdata = 8'h22;
    mid();
    checks++;
    if ({io_gnt, cpu_gnt} !== 2'b00) begin
      failures++;
      $display("FAIL alt_idle got=%b exp=00", {io_gnt, cpu_gnt});
    end
    for (int i = 0; i < 64; i++) begin
      step();
      mid();
      exp_cpu = ((i / 16) % 2) == 0;
      checks++;
      if ({io_gnt, cpu_gnt, ram_write, ram_addr} !== {!exp_cpu, exp_cpu, 1'b1, exp_cpu ? 16'h0200 : 16'h0100}) begin
        failures++;
        $display("FAIL alt_beat%0d got=%b%b%b/%h exp_cpu=%b", i, io_gnt, cpu_gnt, ram_write, ram_addr, exp_cpu);
      end
    end
    step();
    io_req = 0; cpu_req = 0;
    step();
    mid();
    checks++;
    if ({owner, busy} !== 3'b000) begin
      failures++;
      $display("FAIL alt_release got=%b exp=000", {owner, busy});
    end
  endtask
  task automatic test_hold_cpu();
    step();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    io_we = 1; io_addr = 16'h0030; io_wdata = 8'h3C;
    step();
    step();
    hold_cpu = 1; io_req = 1;
    mid();
    checks++;
    if ({cpu_gnt, ram_read, cpu_rvalid} !== 3'b111) begin
      failures++;
      $display("FAIL hold_beat_completes got=%b exp=111", {cpu_gnt, ram_read, cpu_rvalid});
    end
    step();
    mid();
    checks++;
    if ({owner, cpu_gnt, cpu_rvalid, io_rvalid, cpu_rdata} !== {5'b01010, 8'hA5}) begin
      failures++;
      $display("FAIL hold_handover got=%h exp=%h", {owner, cpu_gnt, cpu_rvalid, io_rvalid, cpu_rdata}, {5'b01010, 8'hA5});
    end
    checks++;
    if ({ram_write, ram_addr} !== {1'b1, 16'h0030}) begin
      failures++;
      $display("FAIL hold_io_beat got=%h exp=%h", {ram_write, ram_addr}, {1'b1, 16'h0030});
    end
    step();
    io_req = 0;
    mid();
    checks++;
    if ({cpu_gnt, cpu_rvalid, ram_read, ram_write} !== 4'b0000) begin
      failures++;
      $display("FAIL hold_no_beat got=%b exp=0000", {cpu_gnt, cpu_rvalid, ram_read, ram_write});
    end
    for (int i = 0; i < 2; i++) begin
      step();
      mid();
      checks++;
      if ({owner, cpu_gnt} !== 3'b000) begin
        failures++;
        $display("FAIL hold_blocks_cpu%0d got=%b exp=000", i, {owner, cpu_gnt});
      end
    end
  endtask
  task automatic test_saturate();
    step();
    hold_cpu = 0; cpu_req = 0;
    io_req = 1; io_we = 1; io_addr = 16'h0040; io_wdata = 8'h55;
    for (int i = 0; i < 20; i++) begin
      step();
      mid();
      checks++;
      if ({io_gnt, cpu_gnt, owner} !== 4'b1001) begin
        failures++;
        $display("FAIL saturate%0d got=%b exp=1001", i, {io_gnt, cpu_gnt, owner});
      end
    end
  endtask
  task automatic test_reset_mid();
    step();
    io_we = 0; io_addr = 16'h0010; reset = 0;
    mid();
    checks++;
    if ({io_gnt, ram_read} !== 2'b11) begin
      failures++;
      $display("FAIL rst_mid_beat got=%b exp=11", {io_gnt, ram_read});
    end
    step();
    mid();
    checks++;
    if ({owner, busy, io_gnt, cpu_gnt, io_rvalid, cpu_rvalid, ram_read, ram_write} !== 9'b0) begin
      failures++;
      $display("FAIL rst_mid_ctrl got=%b exp=0", {owner, busy, io_gnt, cpu_gnt, io_rvalid, cpu_rvalid, ram_read, ram_write});
    end
    checks++;
    if ({ram_addr, ram_din, io_rdata, cpu_rdata} !== 40'h0) begin
      failures++;
      $display("FAIL rst_mid_data got=%h exp=0", {ram_addr, ram_din, io_rdata, cpu_rdata});
    end
    step();
    reset = 1;
    mid();
    checks++;
    if ({io_gnt, io_rvalid} !== 2'b00) begin
      failures++;
      $display("FAIL rst_rearb_idle got=%b exp=00", {io_gnt, io_rvalid});
    end
    step();
    mid();
    checks++;
    if ({io_gnt, ram_read, ram_addr} !== {2'b11, 16'h0010}) begin
      failures++;
      $display("FAIL rst_rearb_grant got=%h exp=%h", {io_gnt, ram_read, ram_addr}, {2'b11, 16'h0010});
    end
    step();
    io_req = 0;
    mid();
    checks++;
    if ({io_rvalid, cpu_rvalid, io_rdata} !== {2'b10, 8'hA5}) begin
      failures++;
      $display("FAIL rst_rearb_return got=%h exp=%h", {io_rvalid, cpu_rvalid, io_rdata}, {2'b10, 8'hA5});
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_io_write();
    test_io_read();
    test_alternation();
    test_hold_cpu();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
